// File: rtl/axi_mem_responder.sv
// AXI3-subset INCR-burst slave backed by an internal byte-strobed RAM (read-first).
// Optional address range checking: define AXI_MEM_RANGE_CHECK_EN.
module axi_mem_responder #(
  parameter int AXI_TID_WIDTH = 6,
  parameter int ADDR_W        = 32,
  parameter int AXI_DATA_W    = 64,
  parameter int MEM_ADDR_W    = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AXI_TID_WIDTH-1:0]  S_AXI_AWID,
  input  logic [ADDR_W-1:0]         S_AXI_AWADDR,
  input  logic [3:0]                S_AXI_AWLEN,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [AXI_DATA_W-1:0]     S_AXI_WDATA,
  input  logic [AXI_DATA_W/8-1:0]   S_AXI_WSTRB,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [AXI_TID_WIDTH-1:0]  S_AXI_BID,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [AXI_TID_WIDTH-1:0]  S_AXI_ARID,
  input  logic [ADDR_W-1:0]         S_AXI_ARADDR,
  input  logic [3:0]                S_AXI_ARLEN,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [AXI_TID_WIDTH-1:0]  S_AXI_RID,
  output logic [AXI_DATA_W-1:0]     S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RLAST,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY
);

  localparam int AXI_WSTRB_W = AXI_DATA_W / 8;
  localparam int BYTE_OFF_W  = $clog2(AXI_WSTRB_W);
  localparam int MEM_DEPTH   = 1 << MEM_ADDR_W;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} r_state_t;

  function automatic logic [MEM_ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
    return addr[BYTE_OFF_W +: MEM_ADDR_W];
  endfunction

`ifdef AXI_MEM_RANGE_CHECK_EN
  // Out of range when high address bits are set or the last beat passes the top word.
  function automatic logic range_err(input logic [ADDR_W-1:0] addr, input logic [3:0] len);
    logic [MEM_ADDR_W:0] last_idx;
    last_idx = {1'b0, word_index(addr)} + (MEM_ADDR_W+1)'(len);
    return ((addr >> (BYTE_OFF_W + MEM_ADDR_W)) != '0) || last_idx[MEM_ADDR_W];
  endfunction
`endif

  logic [AXI_DATA_W-1:0] mem [MEM_DEPTH];

  w_state_t                 w_state_r, w_next_s;
  logic [AXI_TID_WIDTH-1:0] bid_r;
  logic [MEM_ADDR_W-1:0]    w_idx_r;
  logic [3:0]               w_len_r, w_cnt_r;
  logic                     w_err_r, aw_err_s;
  logic                     awready_r, wready_r, bvalid_r;
  logic                     awready_s, wready_s, bvalid_s;
  logic [1:0]               bresp_r;
  logic                     aw_hs_s, w_hs_s, b_hs_s, mem_we_s;

  r_state_t                 r_state_r, r_next_s;
  logic [AXI_TID_WIDTH-1:0] r_id_r, rid_r;
  logic [MEM_ADDR_W-1:0]    r_idx_r;
  logic [3:0]               r_len_r, r_cnt_r;
  logic                     r_err_r, ar_err_s;
  logic                     arready_r, rvalid_r, rlast_r;
  logic                     arready_s, rvalid_s;
  logic [AXI_DATA_W-1:0]    rdata_r;
  logic [1:0]               rresp_r;
  logic                     ar_hs_s, r_hs_s;

  logic                     unused_addr_s;

`ifdef AXI_MEM_RANGE_CHECK_EN
  assign aw_err_s = range_err(S_AXI_AWADDR, S_AXI_AWLEN);
  assign ar_err_s = range_err(S_AXI_ARADDR, S_AXI_ARLEN);
`else
  assign aw_err_s = 1'b0;
  assign ar_err_s = 1'b0;
`endif
  assign unused_addr_s = ^{S_AXI_AWADDR, S_AXI_ARADDR};

  assign aw_hs_s  = S_AXI_AWVALID && awready_r;
  assign w_hs_s   = S_AXI_WVALID && wready_r;
  assign b_hs_s   = bvalid_r && S_AXI_BREADY;
  assign mem_we_s = w_hs_s && !w_err_r;
  assign ar_hs_s  = S_AXI_ARVALID && arready_r;
  assign r_hs_s   = rvalid_r && S_AXI_RREADY;

  // Write FSM state and registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
    end else begin
      w_state_r <= w_next_s;
      awready_r <= awready_s;
      wready_r  <= wready_s;
      bvalid_r  <= bvalid_s;
    end
  end

  // Write FSM next state; beat count reaching len ends the burst (WLAST not used)
  always_comb begin
    w_next_s = w_state_r;
    case (w_state_r)
      W_IDLE:  if (aw_hs_s) w_next_s = W_DATA; else w_next_s = W_IDLE;
      W_DATA:  if (w_hs_s && (w_cnt_r == w_len_r)) w_next_s = W_RESP; else w_next_s = W_DATA;
      W_RESP:  if (b_hs_s) w_next_s = W_IDLE; else w_next_s = W_RESP;
      default: w_next_s = W_IDLE;
    endcase
  end

  // Write handshake outputs decoded from the upcoming state
  always_comb begin
    awready_s = 1'b0;
    wready_s  = 1'b0;
    bvalid_s  = 1'b0;
    case (w_next_s)
      W_IDLE:  awready_s = 1'b1;
      W_DATA:  wready_s  = 1'b1;
      W_RESP:  bvalid_s  = 1'b1;
      default: awready_s = 1'b0;
    endcase
  end

  // Write burst bookkeeping and B response fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bid_r   <= '0;
      w_idx_r <= '0;
      w_len_r <= 4'd0;
      w_cnt_r <= 4'd0;
      w_err_r <= 1'b0;
      bresp_r <= 2'b00;
    end else if (aw_hs_s) begin
      bid_r   <= S_AXI_AWID;
      w_idx_r <= word_index(S_AXI_AWADDR);
      w_len_r <= S_AXI_AWLEN;
      w_cnt_r <= 4'd0;
      w_err_r <= aw_err_s;
    end else if (w_hs_s) begin
      w_idx_r <= w_idx_r + MEM_ADDR_W'(1);
      w_cnt_r <= w_cnt_r + 4'd1;
      if (w_cnt_r == w_len_r) bresp_r <= w_err_r ? 2'b10 : 2'b00;
    end
  end

  // Byte-strobed RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < AXI_WSTRB_W; b++) begin
        if (S_AXI_WSTRB[b]) mem[w_idx_r][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
      end
    end
  end

  // Read FSM state and registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
    end else begin
      r_state_r <= r_next_s;
      arready_r <= arready_s;
      rvalid_r  <= rvalid_s;
    end
  end

  // Read FSM next state: one fetch cycle per beat
  always_comb begin
    r_next_s = r_state_r;
    case (r_state_r)
      R_IDLE:  if (ar_hs_s) r_next_s = R_FETCH; else r_next_s = R_IDLE;
      R_FETCH: r_next_s = R_DATA;
      R_DATA: begin
        if (r_hs_s) begin
          if (rlast_r) r_next_s = R_IDLE; else r_next_s = R_FETCH;
        end else begin
          r_next_s = R_DATA;
        end
      end
      default: r_next_s = R_IDLE;
    endcase
  end

  // Read handshake outputs decoded from the upcoming state
  always_comb begin
    arready_s = 1'b0;
    rvalid_s  = 1'b0;
    case (r_next_s)
      R_IDLE:  arready_s = 1'b1;
      R_DATA:  rvalid_s  = 1'b1;
      default: arready_s = 1'b0;
    endcase
  end

  // Read burst bookkeeping and the synchronous, read-first RAM read into R fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_id_r  <= '0;
      r_idx_r <= '0;
      r_len_r <= 4'd0;
      r_cnt_r <= 4'd0;
      r_err_r <= 1'b0;
      rid_r   <= '0;
      rdata_r <= '0;
      rlast_r <= 1'b0;
      rresp_r <= 2'b00;
    end else begin
      if (ar_hs_s) begin
        r_id_r  <= S_AXI_ARID;
        r_idx_r <= word_index(S_AXI_ARADDR);
        r_len_r <= S_AXI_ARLEN;
        r_cnt_r <= 4'd0;
        r_err_r <= ar_err_s;
      end else if (r_hs_s) begin
        r_idx_r <= r_idx_r + MEM_ADDR_W'(1);
        r_cnt_r <= r_cnt_r + 4'd1;
      end
      if (r_state_r == R_FETCH) begin
        rid_r   <= r_id_r;
        rdata_r <= r_err_r ? '0 : mem[r_idx_r];
        rlast_r <= (r_cnt_r == r_len_r);
        rresp_r <= r_err_r ? 2'b10 : 2'b00;
      end
    end
  end

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BID     = bid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RID     = rid_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = rresp_r;
  assign S_AXI_RLAST   = rlast_r;
  assign S_AXI_RVALID  = rvalid_r;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: stimulus pushes expectations from a word-array
// memory model, a negedge monitor pops and compares every B and R handshake.
module tb_axi_mem_responder;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awlen, arlen;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axi_mem_responder dut (
    .clk(clk), .reset(reset),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [5:0] id; logic [63:0] data; logic last; logic [1:0] resp; } r_exp_t;
  b_exp_t b_q[$];
  r_exp_t r_q[$];

  logic [63:0] model_mem [DEPTH];
  logic [63:0] wdat [16];
  logic [7:0]  wstb [16];

  int n_checks = 0;
  int n_pass   = 0;
  int bready_delay = 0;
  bit rready_rand  = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic bit model_err(input logic [31:0] addr, input logic [3:0] len);
`ifdef AXI_MEM_RANGE_CHECK_EN
    int start;
    start = int'(addr[12:3]);
    return (addr[31:13] != 19'd0) || (start + int'(len) > DEPTH - 1);
`else
    return (addr[0] & 1'b0);
`endif
  endfunction

  task automatic wait_hs(input int which, input string name);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if ((which == 0 && awready) || (which == 1 && wready) || (which == 2 && arready)) return;
    end
    check({"timeout_", name}, 1'b0, 1'b1);
  endtask

  task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len);
    bit err;
    int idx;
    err = model_err(addr, len);
    for (int i = 0; i <= int'(len); i++) begin
      idx = (int'(addr[12:3]) + i) % DEPTH;
      if (!err)
        for (int b = 0; b < 8; b++)
          if (wstb[i][b]) model_mem[idx][b*8 +: 8] = wdat[i][b*8 +: 8];
    end
    b_q.push_back('{id, err ? 2'b10 : 2'b00});
    @(posedge clk); #1;
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    wait_hs(0, "awready");
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wdat[i]; wstrb = wstb[i]; wvalid = 1'b1;
      wait_hs(1, "wready");
      @(posedge clk); #1;
      wvalid = 1'b0;
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len);
    bit err;
    int idx;
    err = model_err(addr, len);
    for (int i = 0; i <= int'(len); i++) begin
      idx = (int'(addr[12:3]) + i) % DEPTH;
      r_q.push_back('{id, err ? 64'd0 : model_mem[idx], (i == int'(len)), err ? 2'b10 : 2'b00});
    end
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    wait_hs(2, "arready");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (b_q.size() == 0 && r_q.size() == 0) return;
    end
    check("timeout_drain", 1'b0, 1'b1);
  endtask

  // BREADY: raised bready_delay cycles after BVALID appears, held for one cycle
  int bcnt = 0;
  always begin
    @(posedge clk); #1;
    if (bready) begin
      bready = 1'b0; bcnt = 0;
    end else if (bvalid) begin
      if (bcnt >= bready_delay) bready = 1'b1;
      else bcnt++;
    end
  end

  always begin
    @(posedge clk); #1;
    rready = rready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: stability under stall plus scoreboard compare on every handshake
  logic        p_bvalid = 1'b0, p_bready = 1'b0, p_rvalid = 1'b0, p_rready = 1'b0, p_rlast;
  logic [5:0]  p_bid, p_rid;
  logic [1:0]  p_bresp, p_rresp;
  logic [63:0] p_rdata;
  always @(negedge clk) begin
    if (reset) begin
      if (p_bvalid && !p_bready)
        check("b_stable", {bvalid, bid, bresp}, {1'b1, p_bid, p_bresp});
      if (p_rvalid && !p_rready)
        check("r_stable", {rvalid, rid, rdata, rlast, rresp}, {1'b1, p_rid, p_rdata, p_rlast, p_rresp});
      if (bvalid && bready) begin
        if (b_q.size() == 0) check("b_unexpected", 1'b1, 1'b0);
        else begin
          b_exp_t e;
          e = b_q.pop_front();
          check("b_resp", {bid, bresp}, {e.id, e.resp});
        end
      end
      if (rvalid && rready) begin
        if (r_q.size() == 0) check("r_unexpected", 1'b1, 1'b0);
        else begin
          r_exp_t e;
          e = r_q.pop_front();
          check("r_beat", {rid, rdata, rlast, rresp}, {e.id, e.data, e.last, e.resp});
        end
      end
    end
    p_bvalid = bvalid; p_bready = bready; p_bid = bid; p_bresp = bresp;
    p_rvalid = rvalid; p_rready = rready; p_rid = rid; p_rdata = rdata;
    p_rlast = rlast; p_rresp = rresp;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; bready = 1'b0; rready = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b1;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_awready", awready, 1'b0);
    check("reset_arready", arready, 1'b0);
    check("reset_bvalid", bvalid, 1'b0);
    check("reset_rvalid", rvalid, 1'b0);
    awvalid = 1'b0; arvalid = 1'b0;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check("release_awready", awready, 1'b1);
    check("release_arready", arready, 1'b1);

    // Fill the whole RAM so every later read has a known value
    for (int k = 0; k < 64; k++) begin
      for (int i = 0; i < 16; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
      do_write(6'(k), 32'(k * 128), 4'd15);
    end
    drain();

    // Basic four-beat burst
    wdat[0] = 64'h11; wdat[1] = 64'h22; wdat[2] = 64'h33; wdat[3] = 64'h44;
    for (int i = 0; i < 4; i++) wstb[i] = 8'hFF;
    do_write(6'h2A, 32'h40, 4'd3);
    drain();
    do_read(6'h15, 32'h40, 4'd3);
    drain();

    // Partial strobe overwrite of the low half
    wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstb[0] = 8'hFF;
    do_write(6'h01, 32'h200, 4'd0);
    drain();
    wdat[0] = 64'h0; wstb[0] = 8'h0F;
    do_write(6'h02, 32'h200, 4'd0);
    drain();
    do_read(6'h03, 32'h200, 4'd0);
    drain();

    // Backpressure on both response channels
    rready_rand = 1'b1; bready_delay = 5;
    for (int i = 0; i < 8; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
    do_write(6'h04, 32'h300, 4'd7);
    drain();
    do_read(6'h05, 32'h300, 4'd7);
    drain();

    // Wrap past the top word
    wdat[0] = 64'hAAAA_0000_0000_1023; wdat[1] = 64'hBBBB_0000_0000_0000;
    wstb[0] = 8'hFF; wstb[1] = 8'hFF;
    do_write(6'h06, 32'h1FF8, 4'd1);
    drain();
    do_read(6'h07, 32'h1FF8, 4'd1);
    drain();
    do_read(6'h08, 32'h0, 4'd0);
    drain();

    // Overlapped 16-beat write and read on disjoint regions
    bready_delay = 0;
    for (int i = 0; i < 16; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
    fork
      do_write(6'h09, 32'h800, 4'd15);
      do_read(6'h0A, 32'h1800, 4'd15);
    join
    drain();

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [3:0]  l;
      rready_rand  = 1'($urandom_range(0, 1));
      bready_delay = $urandom_range(0, 3);
      for (int i = 0; i < 16; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'($urandom); end
      a = 32'($urandom_range(0, DEPTH - 1)) << 3;
      if ($urandom_range(0, 7) == 0) a = a | 32'h0001_0000;
      l = 4'($urandom_range(0, 15));
      do_write(6'($urandom), a, l);
      drain();
      a = 32'($urandom_range(0, DEPTH - 1)) << 3;
      l = 4'($urandom_range(0, 15));
      do_read(6'($urandom), a, l);
      drain();
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/axi_mem_responder.md
Name:
axi_mem_responder

Overview:
AXI3-subset slave that answers the DNN memory controller's master port with an internal byte-strobed RAM, serving INCR write and read bursts; used as the DDR stand-in for loopback and PU-controller regressions without a DRAM model.

Parameters:
AXI_TID_WIDTH, 6, width of AWID/BID/ARID/RID
ADDR_W, 32, AXI address width
AXI_DATA_W, 64, data width; AXI_WSTRB_W = AXI_DATA_W/8, BYTE_OFF_W = log2(AXI_WSTRB_W)
MEM_ADDR_W, 10, log2 of RAM depth in AXI_DATA_W words

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
S_AXI_AWID  in  AXI_TID_WIDTH  write burst id
S_AXI_AWADDR  in  ADDR_W  write start byte address
S_AXI_AWLEN  in  4  write beats minus 1
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address accepted
S_AXI_WDATA  in  AXI_DATA_W  write beat data
S_AXI_WSTRB  in  AXI_WSTRB_W  byte enables
S_AXI_WVALID  in  1  write beat valid
S_AXI_WREADY  out  1  write beat accepted
S_AXI_BID  out  AXI_TID_WIDTH  response id = latched AWID
S_AXI_BRESP  out  2  OKAY 2'b00 / SLVERR 2'b10
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response accepted
S_AXI_ARID  in  AXI_TID_WIDTH  read burst id
S_AXI_ARADDR  in  ADDR_W  read start byte address
S_AXI_ARLEN  in  4  read beats minus 1
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address accepted
S_AXI_RID  out  AXI_TID_WIDTH  = latched ARID
S_AXI_RDATA  out  AXI_DATA_W  read beat data
S_AXI_RRESP  out  2  OKAY / SLVERR
S_AXI_RLAST  out  1  final beat of burst
S_AXI_RVALID  out  1  read beat valid
S_AXI_RREADY  in  1  read beat accepted

Behaviour:
- Reset (reset=0, async): all outputs 0, both FSMs idle, beat counters 0; RAM contents not cleared. Reset mid-burst abandons the burst; no B/R issued.
- Word index = ADDR[BYTE_OFF_W+MEM_ADDR_W-1:BYTE_OFF_W]; low BYTE_OFF_W bits ignored; AxBURST/AxSIZE ignored, always INCR full-width; index wraps modulo 2^MEM_ADDR_W.
- Write FSM W_IDLE->W_DATA->W_RESP: AWREADY=1 only in W_IDLE; AW handshake latches id/index/len. W_DATA: WREADY=1; each WVALID&WREADY writes bytes where WSTRB=1, index+1, count+1; beat count==len moves to W_RESP (WLAST ignored). W_RESP: BVALID=1 held until BREADY, then W_IDLE next cycle.
- Read FSM R_IDLE->R_FETCH->R_DATA: ARREADY=1 only in R_IDLE; handshake latches id/index/len. R_FETCH issues 1-cycle synchronous RAM read; R_DATA drives RVALID=1 and registered RDATA, stable until RREADY; RLAST=1 when count==len. Handshake on last beat->R_IDLE, else index+1, ->R_FETCH. Max throughput 1 beat/2 cycles; first RVALID 2 cycles after AR handshake.
- Write and read FSMs independent; same-cycle RAM write and read to one index returns old data (read-first).
- Without range check, BRESP/RRESP always OKAY.

Optional Feature:
AXI_MEM_RANGE_CHECK_EN: defined -> bursts whose start address has any nonzero bit above BYTE_OFF_W+MEM_ADDR_W, or whose index crosses the top, get SLVERR on B and every R beat; out-of-range writes suppressed, out-of-range reads return 0. Undefined -> silent modulo aliasing, always OKAY.

Test Plan:
- Reset: hold reset=0 with AWVALID=ARVALID=1 -> AWREADY=ARREADY=BVALID=RVALID=0; release -> AWREADY=ARREADY=1 next cycle.
- Write AWADDR=0x40, AWLEN=3, data 0x11..0x44, WSTRB=0xFF, BREADY=1 -> one BVALID, BID=AWID, BRESP=0; read ARADDR=0x40 ARLEN=3 -> 0x11,0x22,0x33,0x44, RLAST only on 4th, RID=ARID.
- Partial strobe: write 0xFFFF_FFFF_FFFF_FFFF then 0 with WSTRB=0x0F to same word -> readback 0xFFFF_FFFF_0000_0000.
- Backpressure: RREADY toggles 1/0 random, BREADY delayed 5 cycles -> RDATA/RLAST/BVALID stable while stalled, no beat lost or duplicated.
- Wrap: MEM_ADDR_W=10, AWADDR=0x1FF8, AWLEN=1 -> beats at indices 1023 and 0 (no range check); with AXI_MEM_RANGE_CHECK_EN, BRESP=2'b10 and index 0 unchanged.
- Concurrent: 16-beat write and 16-beat read to disjoint regions overlapped -> both complete with correct data and one B response.
